// File: rtl/mux_lut_pkg.sv
// mux_lut_pkg: shared types and helpers for the mux_lut_cfg lookup-table cell.
//   lut_state_t  : configuration FSM state (READY / LOAD)
//   tt_bits()    : total truth-table width for a given select width and channel count
//   DEFAULT_INIT : power-on table for N_IN=2, CH=2 (ch0 = NOT in[0], ch1 = AND)
package mux_lut_pkg;

  typedef enum logic [0:0] {
    READY = 1'b0,
    LOAD  = 1'b1
  } lut_state_t;

  function automatic int tt_bits(input int n_in, input int ch);
    return ch * (2 ** n_in);
  endfunction

  // Bit c*4+k is channel c at index k: ch0 = 4'b0101, ch1 = 4'b1000.
  localparam logic [7:0] DEFAULT_INIT = 8'h85;

endpackage

// File: rtl/mux_tree.sv
// mux_tree: N_IN-level tree of 2:1 muxes selecting one entry of a truth table.
//   lut [2**N_IN-1:0] : table entries, index k at bit k
//   sel [N_IN-1:0]    : entry index
//   y                 : lut[sel]
// Pure combinational. Stage 0 is the table itself; stage s halves the width
// of stage s-1 using sel[s-1], so the leaves are resolved by the LSB first.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module mux_tree #(
  parameter int N_IN = 2
) (
  input  logic [(2**N_IN)-1:0] lut,
  input  logic [N_IN-1:0]      sel,
  output logic                 y
);

  for (genvar s = 0; s <= N_IN; s++) begin : g_stage
    logic [(2**(N_IN-s))-1:0] v;
    if (s == 0) begin : g_leaf
      assign v = lut;
    end else begin : g_level
      for (genvar j = 0; j < 2**(N_IN-s); j++) begin : g_mux
        mux2 u_mux2 (
          .a (g_stage[s-1].v[2*j]),
          .b (g_stage[s-1].v[2*j+1]),
          .s (sel[s-1]),
          .y (v[j])
        );
      end
    end
  end

  assign y = g_stage[N_IN].v[0];

endmodule

// File: rtl/mux_lut_cfg.sv
// mux_lut_cfg: runtime-reconfigurable multi-channel lookup-table cell.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   cfg_start           : pulse, begins (or restarts) a serial table load
//   cfg_valid, cfg_bit  : serial truth-table stream, bit j -> shadow[j]
//   cfg_ready           : high while in LOAD
//   cfg_done            : one-cycle pulse when the shadow commits to the active table
//   in_valid, in_data   : evaluation request, in_data is the table index
//   out_valid, out_data : registered result one cycle later, bit c = channel c
//   state               : current configuration FSM state (debug)
//
// Handshake: a config bit transfers on a rising edge where cfg_valid and
// cfg_ready are both high and cfg_start is low; cfg_start wins over a
// coincident bit. Evaluation has no backpressure: every in_valid cycle
// produces exactly one out_valid cycle one clock later.
module mux_lut_cfg
  import mux_lut_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int CH   = 2,
  parameter logic [tt_bits(N_IN, CH)-1:0] INIT = DEFAULT_INIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  output logic [CH-1:0]   out_data,
  output lut_state_t      state
);

  localparam int DEPTH   = 2 ** N_IN;
  localparam int TT_BITS = tt_bits(N_IN, CH);
  localparam int CNT_W   = $clog2(TT_BITS + 1);

  logic [TT_BITS-1:0] tt;
  logic [TT_BITS-1:0] shadow;
  logic [TT_BITS-1:0] shadow_next;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last;
  logic [CH-1:0]      lut_y;

  assign cfg_ready = (state == LOAD);
  assign accept    = cfg_ready && cfg_valid && !cfg_start;
  assign last      = accept && (cnt == CNT_W'(TT_BITS - 1));

  // Shadow with the incoming bit already merged in, so the final bit can be
  // committed to the active table on the same edge that accepts it.
  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < TT_BITS; i++) begin
      if (cnt == CNT_W'(i)) begin
        shadow_next[i] = cfg_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= READY;
      cnt      <= '0;
      shadow   <= '0;
      tt       <= INIT;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        READY: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            // Restart: drop whatever was partially loaded.
            cnt    <= '0;
            shadow <= '0;
          end else if (accept) begin
            shadow <= shadow_next;
            if (last) begin
              tt       <= shadow_next;
              cfg_done <= 1'b1;
              state    <= READY;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= READY;
      endcase
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    mux_tree #(.N_IN(N_IN)) u_tree (
      .lut (tt[c*DEPTH +: DEPTH]),
      .sel (in_data),
      .y   (lut_y[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= lut_y;
      end
    end
  end

endmodule

// File: tb/tb_mux_lut_cfg.sv
// tb_mux_lut_cfg: scoreboard bench for mux_lut_cfg (N_IN=2, CH=2).
// The reference model keeps the active table as a plain bit array and the
// pending load as a queue of received bits; a load commits when the queue
// holds CH*DEPTH bits.
module tb_mux_lut_cfg;
  import mux_lut_pkg::*;

  localparam int N_IN    = 2;
  localparam int CH      = 2;
  localparam int DEPTH   = 4;
  localparam int TT_BITS = 8;

  logic            clk;
  logic            rst_n;
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            cfg_done;
  logic            in_valid;
  logic [N_IN-1:0] in_data;
  logic            out_valid;
  logic [CH-1:0]   out_data;
  lut_state_t      state;

  mux_lut_cfg #(.N_IN(N_IN), .CH(CH), .INIT(8'h85)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [TT_BITS-1:0] ref_tt;
  logic               ref_loading;
  logic               ref_done;
  logic               stream_q[$];
  logic [CH-1:0]      exp_q[$];
  int                 total;
  int                 bad;
  int                 done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] model_eval(input logic [N_IN-1:0] d);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = ref_tt[c*DEPTH + int'(d)];
    return r;
  endfunction

  task automatic model_reset();
    ref_tt      = 8'h85;
    ref_loading = 1'b0;
    ref_done    = 1'b0;
    stream_q.delete();
    exp_q.delete();
  endtask

  // Applied right after the active edge that sampled the stimulus.
  task automatic model_update(input logic st, input logic v, input logic b);
    ref_done = 1'b0;
    if (st) begin
      stream_q.delete();
      ref_loading = 1'b1;
    end else if (ref_loading && v) begin
      stream_q.push_back(b);
      if (stream_q.size() == TT_BITS) begin
        for (int j = 0; j < TT_BITS; j++) ref_tt[j] = stream_q[j];
        stream_q.delete();
        ref_loading = 1'b0;
        ref_done    = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic st, input logic v, input logic b,
                      input logic iv, input logic [N_IN-1:0] d);
    cfg_start = st;
    cfg_valid = v;
    cfg_bit   = b;
    in_valid  = iv;
    in_data   = d;
    if (iv) exp_q.push_back(model_eval(d));
    @(posedge clk);
    model_update(st, v, b);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic eval(input logic [N_IN-1:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  // XOR on ch0, OR on ch1, stream order ch0 k0..k3 then ch1 k0..k3.
  logic [TT_BITS-1:0] xor_or;
  initial xor_or = 8'b1110_0110;

  task automatic load_stream(input logic [TT_BITS-1:0] tbl, input int gap,
                             input logic iv, input logic [N_IN-1:0] d);
    step(1'b1, 1'b0, 1'b0, iv, d);
    for (int j = 0; j < TT_BITS; j++) begin
      step(1'b0, 1'b1, tbl[j], iv, d);
      if (j != TT_BITS - 1) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1, iv, d);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic mon_en;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      chk("cfg_ready", 32'(cfg_ready), 32'(ref_loading));
      chk("cfg_done", 32'(cfg_done), 32'(ref_done));
      chk("state", 32'(state), ref_loading ? 32'(LOAD) : 32'(READY));
      if (cfg_done) done_seen++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int done_before;

  initial begin
    total = 0; bad = 0; done_seen = 0; mon_en = 1'b0;
    cfg_start = 0; cfg_valid = 0; cfg_bit = 0; in_valid = 0; in_data = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("reset_cfg_done", 32'(cfg_done), 32'd0);
    chk("reset_state", 32'(state), 32'(READY));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // Default table.
    eval(2'b00); eval(2'b11); eval(2'b10); eval(2'b01);
    idle(1);

    // cfg_valid is ignored outside LOAD.
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    idle(1);

    // Load XOR/OR back to back, then evaluate.
    done_before = done_seen;
    load_stream(xor_or, 0, 1'b0, 2'b00);
    idle(2);
    chk("load_done_count", 32'(done_seen - done_before), 32'd1);
    eval(2'b01); eval(2'b00); eval(2'b11); eval(2'b10);
    idle(1);

    // Same stream with 3-cycle gaps.
    load_stream(xor_or, 3, 1'b0, 2'b00);
    idle(1);
    eval(2'b01); eval(2'b10);
    idle(1);

    // Restart mid-load while sampling index 3 every cycle.
    model_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    idle(1);
    done_before = done_seen;
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'(j & 1), 1'b1, 2'b11);
    load_stream(xor_or, 0, 1'b1, 2'b11);
    eval(2'b11); eval(2'b00);
    idle(2);
    chk("restart_done_count", 32'(done_seen - done_before), 32'd1);

    // Reset mid-load: outputs clear asynchronously, table returns to INIT.
    eval(2'b01);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("async_cfg_done", 32'(cfg_done), 32'd0);
    chk("async_state", 32'(state), 32'(READY));
    model_reset();
    cfg_valid = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    eval(2'b00); eval(2'b11);
    idle(1);

    // Commit on the same edge as an evaluation sample.
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int j = 0; j < TT_BITS - 1; j++) step(1'b0, 1'b1, xor_or[j], 1'b0, 2'b00);
    step(1'b0, 1'b1, xor_or[TT_BITS-1], 1'b1, 2'b00);
    eval(2'b00);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)));
    end
    idle(3);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_lut_cfg.md
Name: mux_lut_cfg

Overview:
- Runtime-reconfigurable lookup-table cell built from trees of 2:1 muxes; generalises "gate from mux plus constants" to any N_IN-input Boolean function on CH independent output channels.
- Truth tables load serially through a valid/ready config port into a shadow register and commit atomically; evaluation runs concurrently with a 1-cycle registered latency.
- Used as a programmable glue-logic element and as a reference cell in combinational-logic exercises.

Parameters:
- N_IN, 2, number of select inputs; DEPTH = 2**N_IN table entries per channel.
- CH, 2, number of output channels, each with its own table.
- INIT, 8'h85 (width CH*DEPTH), active table after reset; default gives ch0 = NOT in_data[0], ch1 = AND.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  one-cycle pulse; begins a new table load.
- cfg_valid  input  1  cfg_bit is valid.
- cfg_bit  input  1  serial truth-table bit.
- cfg_ready  output  1  high while the block accepts config bits.
- cfg_done  output  1  one-cycle pulse when a new table commits.
- in_valid  input  1  in_data is valid.
- in_data  input  N_IN  LUT select (truth-table index).
- out_valid  output  1  out_data is valid.
- out_data  output  CH  LUT results, bit c = channel c.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - active table = INIT, shadow = 0, bit counter = 0, FSM = READY.
  - out_valid = 0, out_data = 0, cfg_ready = 0, cfg_done = 0.
- Table layout: flat vector tt[CH*DEPTH-1:0]; channel c, index k at tt[c*DEPTH+k].
- Serial stream order: stream bit j writes shadow[j], i.e. channel 0 index 0 first, channel CH-1 index DEPTH-1 last.
- FSM states: READY, LOAD.
  - READY: cfg_ready = 0; cfg_valid is ignored. cfg_start moves to LOAD next cycle, with counter = 0.
  - LOAD: cfg_ready = 1. Each cycle with cfg_valid && cfg_ready: shadow[counter] = cfg_bit, counter++.
  - LOAD, on acceptance of bit CH*DEPTH-1: next edge copies shadow to the active table (all bits at once), pulses cfg_done for 1 cycle, FSM returns to READY, counter clears.
  - cfg_start while in LOAD: counter resets to 0, partial shadow is discarded, FSM stays in LOAD. A cfg_valid in that same cycle is not accepted.
- Counter width is $clog2(CH*DEPTH+1); it never exceeds CH*DEPTH-1.
- Evaluation:
  - out_data[c] = tt[c*DEPTH + in_data], computed by an N_IN-level 2:1 mux tree per channel, then registered.
  - out_valid <= in_valid; latency is 1 cycle; throughput is 1 per cycle.
  - When in_valid = 0, out_data holds its previous value and out_valid = 0.
- Evaluation in LOAD uses the old active table; partial loads are never visible at the outputs.
- Commit and in_valid in the same cycle (last bit accepted): that sample uses the old table; samples one cycle later use the new table.
- Reset mid-load: shadow is lost, table returns to INIT, no cfg_done pulse is issued.

Decomposition:
- Package mux_lut_pkg:
  - state enum lut_state_t {READY, LOAD};
  - function tt_bits(n_in, ch) returning CH*(2**N_IN);
  - localparam default INIT.
- Sub-module mux_tree: parameter N_IN, inputs table[2**N_IN-1:0] and sel[N_IN-1:0], output y. It is pure combinational and is built recursively or with a generate loop from 2:1 mux instances. mux_lut_cfg instantiates CH copies.

Test Plan:
- Defaults after reset:
  - in_data=2'b00, in_valid=1 -> next cycle out_valid=1, out_data=2'b01.
  - in_data=2'b11 -> out_data=2'b10.
  - in_data=2'b10 -> out_data=2'b01.
- Load ch0=XOR, ch1=OR:
  - cfg_start, then stream 0,1,1,0,0,1,1,1 -> cfg_done pulses once after the 8th accepted bit.
  - in_data=2'b01 -> out_data=2'b11.
  - in_data=2'b00 -> out_data=2'b00.
  - in_data=2'b11 -> out_data=2'b10.
- Config gaps: same XOR/OR stream with cfg_valid low for 3 cycles between bits -> identical final table. cfg_ready stays 1 throughout LOAD.
- Restart mid-load:
  - send 5 bits, pulse cfg_start, send the full XOR/OR stream -> one cfg_done only.
  - in_data=2'b11 returns 2'b10 (INIT) during the whole load and returns 2'b10 (XOR/OR) afterwards.
- Simultaneous commit: last config bit and in_data=2'b00 in the same cycle -> out_data=2'b01 (old INIT). Next sample 2'b00 -> 2'b00 (new table).
- Reset mid-load: assert rst_n=0 after 4 bits -> outputs 0 immediately (async), FSM READY, no cfg_done. Afterwards in_data=2'b00 -> 2'b01 (INIT restored).
